// File: rtl/bus_copy_dma.sv
// bus_copy_dma: bus-initiator DMA that copies a block of 32-bit words from one bank/address to another.
// Ports: i_clk/i_reset (async, active-low); control i_start, i_stop, i_src_*, i_dst_*, i_length;
// status o_busy, o_done, o_aborted, o_words_left; cart bus o_request, o_write, i_busy, i_ack,
// o_bank, o_address, o_data, i_data. One read then one write per word, one transaction outstanding.
module bus_copy_dma #(
  parameter int LENGTH_WIDTH = 20
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_stop,
  input  logic [3:0]              i_src_bank,
  input  logic [25:0]             i_src_address,
  input  logic [3:0]              i_dst_bank,
  input  logic [25:0]             i_dst_address,
  input  logic [LENGTH_WIDTH-1:0] i_length,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_aborted,
  output logic [LENGTH_WIDTH-1:0] o_words_left,
  output logic                    o_request,
  output logic                    o_write,
  input  logic                    i_busy,
  input  logic                    i_ack,
  output logic [3:0]              o_bank,
  output logic [25:0]             o_address,
  output logic [31:0]             o_data,
  input  logic [31:0]             i_data
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_WAIT = 3'd4;
  logic [2:0]  state;
  logic [3:0]  src_bank, dst_bank;
  logic [25:0] src_addr, dst_addr;
  logic [31:0] word;
  logic        stop_seen, stop, wr_phase;
  // A stop that appears mid-transaction is remembered so it is still honoured at the next boundary.
  assign stop      = i_stop | stop_seen;
  assign wr_phase  = (state == WR_REQ) || (state == WR_WAIT);
  assign o_request = (state == RD_REQ) || (state == WR_REQ);
  assign o_write   = state == WR_REQ;
  assign o_bank    = wr_phase ? dst_bank : src_bank;
  assign o_address = wr_phase ? dst_addr : src_addr;
  assign o_data    = word;
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state        <= IDLE;
      src_bank     <= '0;
      dst_bank     <= '0;
      src_addr     <= '0;
      dst_addr     <= '0;
      word         <= '0;
      stop_seen    <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_aborted    <= 1'b0;
      o_words_left <= '0;
    end else begin
      o_done <= 1'b0;
      if (state != IDLE) stop_seen <= stop;
      case (state)
        IDLE: if (i_start) begin
          o_aborted <= 1'b0;
          stop_seen <= 1'b0;
          if (i_length == '0) o_done <= 1'b1;
          else begin
            src_bank     <= i_src_bank;
            dst_bank     <= i_dst_bank;
            src_addr     <= i_src_address & 26'h3FFFFFC;
            dst_addr     <= i_dst_address & 26'h3FFFFFC;
            o_words_left <= i_length;
            o_busy       <= 1'b1;
            state        <= RD_REQ;
          end
        end
        // Acceptance wins over a same-cycle stop: once accepted, the read must be waited out.
        RD_REQ: if (!i_busy) state <= RD_WAIT;
        else if (stop) begin
          o_done    <= 1'b1;
          o_aborted <= 1'b1;
          o_busy    <= 1'b0;
          state     <= IDLE;
        end
        RD_WAIT: if (i_ack) begin
          if (stop) begin
            o_done    <= 1'b1;
            o_aborted <= 1'b1;
            o_busy    <= 1'b0;
            state     <= IDLE;
          end else begin
            word  <= i_data;
            state <= WR_REQ;
          end
        end
        WR_REQ: if (!i_busy) state <= WR_WAIT;
        WR_WAIT: if (i_ack) begin
          o_words_left <= o_words_left - 1'b1;
          src_addr     <= src_addr + 26'd4;
          dst_addr     <= dst_addr + 26'd4;
          if (o_words_left == LENGTH_WIDTH'(1)) begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= IDLE;
          end else if (stop) begin
            o_done    <= 1'b1;
            o_aborted <= 1'b1;
            o_busy    <= 1'b0;
            state     <= IDLE;
          end else state <= RD_REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_copy_dma.sv
// tb_bus_copy_dma: directed and randomized copies of bus_copy_dma against a transaction-level reference.
// A bus responder logs every accepted transaction; expectations come from address/data arithmetic.
module tb_bus_copy_dma;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0, i_stop = 1'b0;
  logic [3:0]  i_src_bank = '0, i_dst_bank = '0;
  logic [25:0] i_src_address = '0, i_dst_address = '0;
  logic [19:0] i_length = '0;
  logic        o_busy, o_done, o_aborted, o_request, o_write;
  logic [19:0] o_words_left;
  logic        i_busy = 1'b0, i_ack = 1'b0;
  logic [3:0]  o_bank;
  logic [25:0] o_address;
  logic [31:0] o_data;
  logic [31:0] i_data = '0;

  bus_copy_dma dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(i_start), .i_stop(i_stop),
    .i_src_bank(i_src_bank), .i_src_address(i_src_address),
    .i_dst_bank(i_dst_bank), .i_dst_address(i_dst_address), .i_length(i_length),
    .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted), .o_words_left(o_words_left),
    .o_request(o_request), .o_write(o_write), .i_busy(i_busy), .i_ack(i_ack),
    .o_bank(o_bank), .o_address(o_address), .o_data(o_data), .i_data(i_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [3:0]  bank;
    logic [25:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        log_q[$];
  int          checks = 0, failures = 0;
  int          busy_first = 0, busy_max = 0, ack_lat = 0;
  int          nreads = 0, first_run = 0, addr_changes = 0;
  logic [31:0] rd_base = '0;

  int          bcnt = 0, dly = 0, run = 0;
  bit          pend = 0, pend_w = 0, in_req = 0;
  logic [31:0] pend_data = '0;
  logic [3:0]  req_bank = '0;
  logic [25:0] req_addr = '0;

  // Responder: decides i_busy/i_ack on the falling edge for the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 0; in_req = 0; i_busy = 1'b0; i_ack = 1'b0;
    end else begin
      i_ack = 1'b0;
      i_data = $urandom;
      if (pend) begin
        if (dly == 0) begin
          i_ack = 1'b1; pend = 0;
          if (!pend_w) i_data = pend_data;
        end else dly--;
      end
      if (o_request) begin
        if (!in_req) begin
          in_req = 1; run = 0; req_addr = o_address; req_bank = o_bank;
          bcnt = (log_q.size() == 0) ? busy_first : $urandom_range(0, busy_max);
        end
        run++;
        if (o_address !== req_addr || o_bank !== req_bank) addr_changes++;
        if (bcnt > 0) begin
          i_busy = 1'b1; bcnt--;
        end else begin
          i_busy = 1'b0; in_req = 0;
          if (log_q.size() == 0) first_run = run;
          log_q.push_back('{o_write, o_bank, o_address, o_data});
          pend = 1; dly = ack_lat; pend_w = o_write;
          pend_data = rd_base + 32'(nreads);
          if (!o_write) nreads++;
        end
      end else begin
        i_busy = 1'b0; in_req = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_copy(input logic [3:0] sb, input logic [25:0] sa, input logic [3:0] db,
                            input logic [25:0] da, input int len, input logic [31:0] base);
    log_q.delete(); nreads = 0; rd_base = base;
    i_src_bank = sb; i_src_address = sa; i_dst_bank = db; i_dst_address = da;
    i_length = 20'(len); i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 1;
    while (o_done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ":done"}, 64'(o_done), 64'd1);
  endtask

  // Reference: word i reads src+4i and writes dst+4i (mod 2^26) with the i-th read value.
  task automatic verify_full(input string tag, input logic [3:0] sb, input logic [25:0] sa,
                             input logic [3:0] db, input logic [25:0] da, input int len,
                             input logic [31:0] base);
    logic [25:0] ar, aw;
    check({tag, ":log_size"}, 64'(log_q.size()), 64'(2 * len));
    for (int i = 0; i < len && 2 * i + 1 < log_q.size(); i++) begin
      ar = {sa[25:2], 2'b00} + 26'(4 * i);
      aw = {da[25:2], 2'b00} + 26'(4 * i);
      check($sformatf("%s:rd%0d", tag, i), {log_q[2*i].w, log_q[2*i].bank, log_q[2*i].addr},
            {1'b0, sb, ar});
      check($sformatf("%s:wr%0d", tag, i),
            {log_q[2*i+1].w, log_q[2*i+1].bank, log_q[2*i+1].addr, log_q[2*i+1].data},
            {1'b1, db, aw, base + 32'(i)});
    end
    check({tag, ":words_left"}, 64'(o_words_left), 64'd0);
    check({tag, ":aborted"}, 64'(o_aborted), 64'd0);
    check({tag, ":busy"}, 64'(o_busy), 64'd0);
    @(negedge clk);
    check({tag, ":done_once"}, 64'(o_done), 64'd0);
  endtask

  initial begin
    int cyc, len, k;
    logic [3:0]  sb, db;
    logic [25:0] sa, da;
    logic [31:0] base;

    repeat (2) @(negedge clk);
    check("reset:outputs", {o_busy, o_done, o_aborted, o_request, o_words_left, o_bank, o_address, o_data},
          64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Three words, zero-wait responder.
    start_copy(4'd1, 26'h0000100, 4'd1, 26'h0001000, 3, 32'hA0);
    check("t1:req_after_start", {o_request, o_write, o_busy}, 3'b101);
    wait_done("t1", cyc);
    check("t1:cycles", 64'(cyc), 64'd13);
    verify_full("t1", 4'd1, 26'h0000100, 4'd1, 26'h0001000, 3, 32'hA0);

    // First read held off by 5 busy cycles.
    busy_first = 5;
    start_copy(4'd2, 26'h0000200, 4'd3, 26'h0002000, 1, 32'h1234_0000);
    wait_done("busy", cyc);
    check("busy:req_cycles", 64'(first_run), 64'd6);
    verify_full("busy", 4'd2, 26'h0000200, 4'd3, 26'h0002000, 1, 32'h1234_0000);
    busy_first = 0;

    // Zero length: no bus activity, done next cycle, never busy.
    start_copy(4'd1, 26'h0, 4'd1, 26'h100, 0, 32'h0);
    check("len0:done", {o_done, o_busy, o_request}, 3'b100);
    repeat (4) @(negedge clk);
    check("len0:no_bus", 64'(log_q.size()), 64'd0);
    check("len0:done_once", {o_done, o_busy}, 2'b00);

    // Source address wrap, with unaligned low bits ignored.
    start_copy(4'd5, 26'h3FFFFFE, 4'd6, 26'h0000011, 2, 32'h5000);
    wait_done("wrap", cyc);
    check("wrap:rd1_addr", (log_q.size() > 2) ? 64'(log_q[2].addr) : 64'hDEAD, 64'd0);
    verify_full("wrap", 4'd5, 26'h3FFFFFE, 4'd6, 26'h0000011, 2, 32'h5000);

    // Stop during the second word's read wait.
    ack_lat = 3;
    start_copy(4'd7, 26'h0000400, 4'd8, 26'h0004000, 4, 32'hB0);
    k = 0;
    while (log_q.size() < 3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    i_stop = 1'b1;
    wait_done("stop", cyc);
    i_stop = 1'b0;
    check("stop:aborted", {o_aborted, o_busy}, 2'b10);
    check("stop:words_left", 64'(o_words_left), 64'd3);
    check("stop:log_size", 64'(log_q.size()), 64'd3);
    check("stop:wr0", (log_q.size() > 1) ? {log_q[1].w, log_q[1].addr, log_q[1].data} : 64'hDEAD,
          {1'b1, 26'h0004000, 32'hB0});
    repeat (6) @(negedge clk);
    check("stop:no_more_bus", 64'(log_q.size()), 64'd3);

    // Asynchronous reset during the first write's wait.
    ack_lat = 4;
    start_copy(4'd9, 26'h0000800, 4'd10, 26'h0008000, 3, 32'hC0);
    k = 0;
    while (log_q.size() < 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("rst:outputs", {o_request, o_busy, o_done, o_words_left}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ack_lat = 0;
    @(negedge clk);
    start_copy(4'd11, 26'h0000C00, 4'd12, 26'h000C000, 1, 32'hD0);
    wait_done("rst_after", cyc);
    verify_full("rst_after", 4'd11, 26'h0000C00, 4'd12, 26'h000C000, 1, 32'hD0);

    // Randomized copies with random wait states.
    for (int n = 0; n < 6; n++) begin
      sb = 4'($urandom); db = 4'($urandom);
      sa = (n % 2 == 1) ? (26'h3FFFFF0 | 26'($urandom_range(0, 15))) : 26'($urandom);
      da = 26'($urandom);
      len = $urandom_range(1, 5);
      base = $urandom;
      busy_first = $urandom_range(0, 2);
      busy_max = $urandom_range(0, 2);
      ack_lat = $urandom_range(0, 2);
      start_copy(sb, sa, db, da, len, base);
      wait_done($sformatf("rnd%0d", n), cyc);
      verify_full($sformatf("rnd%0d", n), sb, sa, db, da, len, base);
    end

    check("bus:addr_stable", 64'(addr_changes), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
